// File: rtl/shift_add_multiplier_8x8.sv
// Signed 8x8 shift-add multiplier: eight add/shift iterations over {X,A,B},
// with the last add turned into a subtract (Booth-style sign correction).

module adder_9_bit (
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic       c_in,
  output logic [8:0] s,
  output logic       c_out
);
  assign {c_out, s} = {1'b0, x} + {1'b0, y} + {9'b0, c_in};
endmodule

module shift_add_multiplier_8x8 #(
  parameter int unsigned N_BITS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              ClearA_LoadB,
  input  logic [N_BITS-1:0] S,
  output logic [N_BITS-1:0] Aval,
  output logic [N_BITS-1:0] Bval,
  output logic              Xval,
  output logic              Busy,
  output logic              Done
);

  if (N_BITS != 8) begin : g_width_check
    $error("shift_add_multiplier_8x8: N_BITS must be 8 to match adder_9_bit");
  end

  // ADDk/SHIFTk are represented as a phase plus iteration index k in cnt_q.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic              x_q, x_d;
  logic              run_q;

  logic              sub;
  logic [N_BITS:0]   add_x, add_y, add_s;
  logic              adder_cout_unused;

  assign sub   = (cnt_q == 3'd7);
  assign add_x = {a_q[N_BITS-1], a_q};
  assign add_y = sub ? ~{S[N_BITS-1], S} : {S[N_BITS-1], S};

  adder_9_bit u_adder (
    .x     (add_x),
    .y     (add_y),
    .c_in  (sub),
    .s     (add_s),
    .c_out (adder_cout_unused)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ClearA_LoadB) begin
          b_d = S;
          a_d = '0;
          x_d = 1'b0;
        end else if (Run && !run_q) begin
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = add_s;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        a_d = {x_q, a_q[N_BITS-1:1]};
        b_d = {a_q[0], b_q[N_BITS-1:1]};
        if (cnt_q == 3'd7) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = ST_ADD;
        end
      end
      ST_HOLD: begin
        if (!Run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      run_q   <= Run;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign Busy = (state_q == ST_ADD) || (state_q == ST_SHIFT);
  assign Done = (state_q == ST_HOLD);

endmodule
